// File: rtl/rv32.sv
// rv32: architectural constants shared by the Ranger core's CSR-facing blocks.
//   XLEN - register and CSR width in bits.
package rv32;
  localparam int XLEN = 32;
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: trap request handshake between the interrupt controller and
// the core's trap logic.
//   irq_req   - controller -> core, trap request level
//   irq_cause - controller -> core, mcause value for the pending request
//   irq_ack   - core -> controller, one-cycle pulse, trap taken
//   mret      - core -> controller, one-cycle pulse, mret retired
// master: the interrupt controller; slave: the core.
interface irq_ctrl_if;
  logic                   irq_req;
  logic [rv32::XLEN-1:0]  irq_cause;
  logic                   irq_ack;
  logic                   mret;

  modport master (output irq_req, output irq_cause, input irq_ack, input mret);
  modport slave  (input irq_req, input irq_cause, output irq_ack, output mret);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt controller for the Ranger core.
// Collects MTI, MSI and MEI levels, keeps the mip pending view, masks it with
// mie and mstatus.MIE, and raises one prioritized trap request
// (MEI > MSI > MTI) with its mcause value. After an ack, further requests are
// held off until mret.
// Ports:
//   clk, rst       - single clock, synchronous active-high reset
//   mti_irq        - timer interrupt level (clk domain)
//   msi_irq        - software interrupt level (clk domain)
//   mei_irq_async  - external interrupt level, asynchronous
//   mie            - mie CSR (bits 3, 7, 11 used)
//   mstatus_mie    - global machine interrupt enable
//   mip            - registered pending view (bits 3, 7, 11 live)
//   irq_bus        - req/cause/ack/mret handshake (master side)
module irq_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mti_irq,
  input  logic                  msi_irq,
  input  logic                  mei_irq_async,
  input  logic [rv32::XLEN-1:0] mie,
  input  logic                  mstatus_mie,
  output logic [rv32::XLEN-1:0] mip,
  irq_ctrl_if.master            irq_bus
);

  localparam int XLEN = rv32::XLEN;

  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   mei_s;
  logic                   msip_q;
  logic                   mtip_q;
  logic                   meip_q;

  state_e                 state_q;
  logic                   req_q;
  logic [XLEN-1:0]        cause_q;

  logic                   elig_msi;
  logic                   elig_mti;
  logic                   elig_mei;
  logic                   elig_any;
  logic [3:0]             sel_code;
  logic                   latched_elig;
  logic                   unused_mie;

  // Only the three machine interrupt enables matter here.
  assign unused_mie = ^{mie[XLEN-1:12], mie[10:8], mie[6:4], mie[2:0]};

  // Synchronizer and pending register: levels reloaded every cycle, no sticky bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      msip_q <= 1'b0;
      mtip_q <= 1'b0;
      meip_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mei_irq_async};
      msip_q <= msi_irq;
      mtip_q <= mti_irq;
      meip_q <= mei_s;
    end
  end

  assign mei_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    mip     = '0;
    mip[3]  = msip_q;
    mip[7]  = mtip_q;
    mip[11] = meip_q;
  end

  // Eligible set and fixed priority selection.
  assign elig_msi = msip_q & mie[3]  & mstatus_mie;
  assign elig_mti = mtip_q & mie[7]  & mstatus_mie;
  assign elig_mei = meip_q & mie[11] & mstatus_mie;
  assign elig_any = elig_msi | elig_mti | elig_mei;

  always_comb begin
    sel_code = CODE_MTI;
    if (elig_mei) begin
      sel_code = CODE_MEI;
    end else if (elig_msi) begin
      sel_code = CODE_MSI;
    end
  end

  // Withdrawal follows only the source that was latched, not whatever is highest now.
  always_comb begin
    latched_elig = 1'b0;
    case (cause_q[3:0])
      CODE_MEI: latched_elig = elig_mei;
      CODE_MSI: latched_elig = elig_msi;
      CODE_MTI: latched_elig = elig_mti;
      default:  latched_elig = 1'b0;
    endcase
  end

  // Request FSM with registered req/cause outputs; cause reads 0 outside REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (elig_any) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            cause_q <= {1'b1, {(XLEN-5){1'b0}}, sel_code};
          end
        end
        REQ: begin
          // Ack beats a simultaneous withdrawal.
          if (irq_bus.irq_ack) begin
            state_q <= BUSY;
            req_q   <= 1'b0;
            cause_q <= '0;
          end else if (!latched_elig) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cause_q <= '0;
          end
        end
        BUSY: begin
          if (irq_bus.mret) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          cause_q <= '0;
        end
      endcase
    end
  end

  assign irq_bus.irq_req   = req_q;
  assign irq_bus.irq_cause = cause_q;

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Machine-mode interrupt controller for the Ranger core, directly downstream of the machine timer. It collects the timer, software and external interrupt lines, keeps the `mip` pending view for the CSR file, and masks pending sources with `mie` and `mstatus.MIE`. It then presents a single prioritized trap request, with its `mcause` value, to the core's trap logic through a req/ack handshake. After the trap is accepted it blocks further requests until `mret`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for the asynchronous external interrupt line; legal values are 2 or more.

Ports:
- `clk`  in  1  system clock; the block has a single clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `mti_irq`  in  1  machine timer interrupt level from the timer (`mtime >= mtimecmp`); synchronous to `clk`.
- `msi_irq`  in  1  machine software interrupt level (`msip` bit); synchronous to `clk`.
- `mei_irq_async`  in  1  external interrupt level; asynchronous.
- `mie`  in  rv32::XLEN  current `mie` CSR value; only bits 3, 7 and 11 are used.
- `mstatus_mie`  in  1  global machine interrupt enable.
- `irq_ack`  in  1  one-cycle pulse from the core: trap taken at `irq_cause`.
- `mret`  in  1  one-cycle pulse: `mret` retired.
- `mip`  out  rv32::XLEN  pending view for CSR reads; bits 3, 7 and 11 are live, all other bits are 0.
- `irq_req`  out  1  trap request to the core.
- `irq_cause`  out  rv32::XLEN  `mcause` value for the request.

## Operation
- Synchronizer: `mei_irq_async` passes through `SYNC_STAGES` flops; the last stage is `mei_s`.
- Pending register: `mip` is registered and reloaded every cycle.
  - `mip[3]` <= `msi_irq`.
  - `mip[7]` <= `mti_irq`.
  - `mip[11]` <= `mei_s`.
  - Sources are levels. The block has no sticky pending bits; a source is cleared by clearing it at its origin.
- Eligible set: `elig = mip & mie & {XLEN{mstatus_mie}}`, evaluated over bits 11, 3 and 7.
- Priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
- Cause encoding: `irq_cause = 32'h8000_0000 | code`.
  - MEI gives `0x8000000B`, MSI gives `0x80000003`, MTI gives `0x80000007`.
  - `irq_cause` reads 0 whenever the state is not REQ.
- State machine:
  - IDLE: if any bit of `elig` is set, latch the highest-priority code and go to REQ.
  - REQ: `irq_req` = 1 and the latched cause is held stable.
    - If `irq_ack` = 1, go to BUSY.
    - Otherwise, if the latched source's `elig` bit is 0, withdraw to IDLE.
    - A higher-priority source arriving during REQ does not replace the latched cause.
  - BUSY: `irq_req` = 0. Go to IDLE on `mret`. Other sources remain visible in `mip` but are not requested.
- Simultaneous events and ignored inputs:
  - In REQ, `irq_ack` together with withdrawal: the ack wins and the state goes to BUSY.
  - `irq_ack` outside REQ is ignored.
  - `mret` outside BUSY is ignored.
  - In BUSY, `mret` with `elig` non-zero: go to IDLE, then re-enter REQ on the next cycle.
- Reset: on any cycle with `rst` = 1, the following clear at the next edge, from any state and mid-handshake:
  - the state returns to IDLE;
  - `mip`, the synchronizer flops and the latched cause go to 0;
  - `irq_req` goes to 0 and `irq_cause` goes to 0.

## Timing
- Reset values: `mip` = 0, `irq_req` = 0, `irq_cause` = 0, state = IDLE.
- `mti_irq`/`msi_irq` rising at edge N: `mip` bit set after edge N+1; `irq_req` high after edge N+2, provided the source is enabled.
- `mei_irq_async` rising before edge N: `mip[11]` set after edge N+`SYNC_STAGES`; `irq_req` high after edge N+`SYNC_STAGES`+1.
- `irq_req` and `irq_cause` are register outputs with no combinational path from any input.
- `irq_ack` sampled at edge M: `irq_req` is low after edge M, and the core must not see a second request for the same trap.
- `mret` sampled at edge K: state is IDLE after K; `irq_req` is re-asserted after K+1 at the earliest.
- Disable during REQ:
  - `mstatus_mie` or the `mie` bit drops at edge W without an ack: `irq_req` is low after edge W+1.
  - The source line itself drops: `irq_req` is low one cycle later than that, because `mip` is registered.

## Test plan
- Reset and single timer interrupt: hold `rst` for 3 cycles, then `mie[7]` = 1, `mstatus_mie` = 1, raise `mti_irq` -> `mip` = `0x80` after 1 edge; `irq_req` = 1 with `irq_cause` = `0x80000007` after 2 edges. Pulse `irq_ack` -> `irq_req` = 0 and `irq_req` stays 0 while `mti_irq` stays high. Pulse `mret` -> `irq_req` = 1 again 2 cycles later.
- Priority: raise `msi_irq` and `mti_irq` together and `mei_irq_async` 1 cycle earlier, all enabled -> first `irq_cause` = `0x8000000B`. After ack, `mret` and dropping `mei_irq_async` -> next `irq_cause` = `0x80000003`.
- Withdrawal: in REQ with cause `0x80000007`, drop `mti_irq` with no ack -> `irq_req` = 0 two cycles later and the state is IDLE. Repeat with `irq_ack` in the withdrawal cycle -> the ack wins and the state is BUSY.
- Masking: `mti_irq` = 1 with `mstatus_mie` = 0 -> `mip` = `0x80` and `irq_req` stays 0 for 20 cycles. Set `mstatus_mie` = 1 -> `irq_req` = 1 one edge later.
- Spurious controls: pulse `irq_ack` and `mret` while in IDLE and while in REQ (except `irq_ack` in REQ) -> no state change and no `irq_req` glitch.
- Reset mid-operation: assert `rst` for 1 cycle while in REQ, and separately while in BUSY -> after the edge, `irq_req` = 0, `irq_cause` = 0, `mip` = 0. With the source still enabled, `irq_req` returns 2 edges after reset deasserts.
